// File: rtl/axi_w_tap_stream.sv
// AXI W-channel tap: forwards beats with zero latency, captures {wlast, wdata}
// into a FIFO and streams out only complete bursts on a valid/ready/in_progress port.
module axi_w_tap_stream #(
   parameter int DATA_WIDTH = 128,
   parameter int ID_WIDTH   = 32,
   parameter int USER_WIDTH = 64,
   parameter int BURST_LEN  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int BLOCKING   = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ready,
   output logic                    valid,
   output logic                    in_progress,
   output logic [DATA_WIDTH-1:0]   data,
   output logic                    last,
   output logic [15:0]             drop_count,
   output logic                    oversize,
   input  logic [ID_WIDTH-1:0]     AXIS_wid,
   input  logic [DATA_WIDTH-1:0]   AXIS_wdata,
   input  logic [DATA_WIDTH/8-1:0] AXIS_wstrb,
   input  logic                    AXIS_wlast,
   input  logic [USER_WIDTH-1:0]   AXIS_wuser,
   input  logic                    AXIS_wvalid,
   output logic                    AXIS_wready,
   output logic [ID_WIDTH-1:0]     AXIM_wid,
   output logic [DATA_WIDTH-1:0]   AXIM_wdata,
   output logic [DATA_WIDTH/8-1:0] AXIM_wstrb,
   output logic                    AXIM_wlast,
   output logic [USER_WIDTH-1:0]   AXIM_wuser,
   output logic                    AXIM_wvalid,
   input  logic                    AXIM_wready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(BURST_LEN + 1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       count, burst_cnt;
   logic [BW-1:0]       beat_idx;
   logic                sob, admit_reg;
   logic [0:0]          state;

   logic full, empty, gate, acc, fits, admit_now;
   logic push, push_last, pop, pop_last, head_last;

   assign AXIM_wid   = AXIS_wid;
   assign AXIM_wdata = AXIS_wdata;
   assign AXIM_wstrb = AXIS_wstrb;
   assign AXIM_wlast = AXIS_wlast;
   assign AXIM_wuser = AXIS_wuser;

   assign full        = (count == CW'(FIFO_DEPTH));
   assign empty       = (count == '0);
   assign gate        = (BLOCKING != 0) ? !full : 1'b1;
   assign AXIM_wvalid = AXIS_wvalid & gate;
   assign AXIS_wready = AXIM_wready & gate;
   assign acc         = AXIS_wvalid & AXIS_wready;

   // Dropping mode admits a burst only if a maximal burst is guaranteed to fit.
   assign fits      = (CW'(FIFO_DEPTH) - count) >= CW'(BURST_LEN);
   assign admit_now = (BLOCKING != 0) ? 1'b1 : (sob ? fits : admit_reg);
   assign push      = acc & admit_now & (beat_idx < BW'(BURST_LEN));
   assign push_last = AXIS_wlast | (beat_idx == BW'(BURST_LEN - 1));

   assign head_last   = mem[rd_ptr][DATA_WIDTH];
   assign valid       = (burst_cnt != '0);
   assign pop         = ready & ((state == ST_STREAM) | valid);
   assign pop_last    = pop & head_last;
   assign in_progress = (state == ST_STREAM) | (valid & ready);
   assign data        = empty ? '0 : mem[rd_ptr][DATA_WIDTH-1:0];
   assign last        = !empty & head_last;

   // NOTE: storage array has no reset; the pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {push_last, AXIS_wdata};
   end

   // NOTE: every register below uses non-blocking assignment so all updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         burst_cnt  <= '0;
         beat_idx   <= '0;
         sob        <= 1'b1;
         admit_reg  <= 1'b0;
         state      <= ST_IDLE;
         drop_count <= '0;
         oversize   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);

         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         case ({push & push_last, pop_last})
            2'b10:   burst_cnt <= burst_cnt + CW'(1);
            2'b01:   burst_cnt <= burst_cnt - CW'(1);
            default: burst_cnt <= burst_cnt;
         endcase

         if (acc) begin
            sob <= AXIS_wlast;
            if (sob) admit_reg <= admit_now;
            if (AXIS_wlast)                      beat_idx <= '0;
            else if (beat_idx < BW'(BURST_LEN)) beat_idx <= beat_idx + BW'(1);
            // beat_idx saturates at BURST_LEN only after a force-terminated beat.
            if (beat_idx == BW'(BURST_LEN)) oversize <= 1'b1;
            if ((BLOCKING == 0) && sob && !fits && (drop_count != 16'hFFFF))
               drop_count <= drop_count + 16'd1;
         end

         case (state)
            ST_IDLE:   if (pop && !head_last) state <= ST_STREAM;
            ST_STREAM: if (pop_last)          state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_w_tap_stream.sv
// Directed bench: one blocking and one dropping instance share the W stimulus;
// each phase resets both and checks the instance under test against hand-derived values.
`timescale 1ns/1ps
module tb_axi_w_tap_stream;

   localparam int DW = 128;
   localparam int IW = 32;
   localparam int UW = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic            ready;
   logic [IW-1:0]   s_wid;
   logic [DW-1:0]   s_wdata;
   logic [DW/8-1:0] s_wstrb;
   logic            s_wlast;
   logic [UW-1:0]   s_wuser;
   logic            s_wvalid;
   logic            m_wready;

   logic            b_valid, b_inprog, b_last, b_over, b_swready;
   logic [DW-1:0]   b_data;
   logic [15:0]     b_drop;
   logic [IW-1:0]   b_mwid;
   logic [DW-1:0]   b_mwdata;
   logic [DW/8-1:0] b_mwstrb;
   logic            b_mwlast, b_mwvalid;
   logic [UW-1:0]   b_mwuser;

   logic            d_valid, d_inprog, d_last, d_over, d_swready;
   logic [DW-1:0]   d_data;
   logic [15:0]     d_drop;
   logic [IW-1:0]   d_mwid;
   logic [DW-1:0]   d_mwdata;
   logic [DW/8-1:0] d_mwstrb;
   logic            d_mwlast, d_mwvalid;
   logic [UW-1:0]   d_mwuser;

   int checks   = 0;
   int failures = 0;
   int beat;

   always #5 clk = ~clk;

   axi_w_tap_stream #(.BLOCKING(1)) dut_b (
      .clk(clk), .reset(reset), .ready(ready),
      .valid(b_valid), .in_progress(b_inprog), .data(b_data), .last(b_last),
      .drop_count(b_drop), .oversize(b_over),
      .AXIS_wid(s_wid), .AXIS_wdata(s_wdata), .AXIS_wstrb(s_wstrb), .AXIS_wlast(s_wlast),
      .AXIS_wuser(s_wuser), .AXIS_wvalid(s_wvalid), .AXIS_wready(b_swready),
      .AXIM_wid(b_mwid), .AXIM_wdata(b_mwdata), .AXIM_wstrb(b_mwstrb), .AXIM_wlast(b_mwlast),
      .AXIM_wuser(b_mwuser), .AXIM_wvalid(b_mwvalid), .AXIM_wready(m_wready)
   );

   axi_w_tap_stream #(.BLOCKING(0)) dut_d (
      .clk(clk), .reset(reset), .ready(ready),
      .valid(d_valid), .in_progress(d_inprog), .data(d_data), .last(d_last),
      .drop_count(d_drop), .oversize(d_over),
      .AXIS_wid(s_wid), .AXIS_wdata(s_wdata), .AXIS_wstrb(s_wstrb), .AXIS_wlast(s_wlast),
      .AXIS_wuser(s_wuser), .AXIS_wvalid(s_wvalid), .AXIS_wready(d_swready),
      .AXIM_wid(d_mwid), .AXIM_wdata(d_mwdata), .AXIM_wstrb(d_mwstrb), .AXIM_wlast(d_mwlast),
      .AXIM_wuser(d_mwuser), .AXIM_wvalid(d_mwvalid), .AXIM_wready(m_wready)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input int d, input logic l);
      s_wvalid = v;
      s_wdata  = DW'(d);
      s_wid    = IW'(d);
      s_wstrb  = '1;
      s_wuser  = UW'(d) << 8;
      s_wlast  = l;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      ready = 1'b0;
      m_wready = 1'b1;
      drive(1'b0, 0, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      ready = 1'b0;
      m_wready = 1'b1;
      drive(1'b0, 0, 1'b0);

      // ---- Reset state, then one 4-beat burst streamed with ready held high
      do_reset();
      #1;
      check("rst_valid", b_valid, 0);
      check("rst_inprog", b_inprog, 0);
      check("rst_last", b_last, 0);
      check("rst_data", b_data, 0);
      check("rst_drop", b_drop, 0);
      check("rst_over", b_over, 0);
      check("rst_swready", b_swready, 1);

      ready = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         drive(1'b1, n, n == 4);
         #1;
         check("p1_mwdata", b_mwdata, n);
         check("p1_mwid", b_mwid, n);
         check("p1_mwvalid", b_mwvalid, 1);
         check("p1_mwlast", b_mwlast, (n == 4));
         check("p1_swready", b_swready, 1);
         check("p1_valid_early", b_valid, 0);
      end
      @(negedge clk);
      drive(1'b0, 0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         check("p1_valid", b_valid, 1);
         check("p1_inprog", b_inprog, 1);
         check("p1_data", b_data, k);
         check("p1_last", b_last, (k == 4));
      end
      @(negedge clk);
      #1;
      check("p1_end_inprog", b_inprog, 0);
      check("p1_end_valid", b_valid, 0);

      // ---- Blocking back-pressure: fill 16 entries with the stream stalled
      do_reset();
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         drive(1'b1, n, (n % 8) == 0);
         #1;
         check("p2_fill_swready", b_swready, 1);
      end
      @(negedge clk);
      beat = 17;
      drive(1'b1, beat, 1'b0);
      #1;
      check("p2_full_swready", b_swready, 0);
      check("p2_full_mwvalid", b_mwvalid, 0);
      check("p2_full_valid", b_valid, 1);
      ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) begin
            @(negedge clk);
            drive(1'b1, beat, (beat % 8) == 0);
         end
         #1;
         check("p2_drain_data", b_data, k);
         check("p2_drain_last", b_last, (k == 8));
         check("p2_drain_swready", b_swready, (k != 1));
         if (b_swready) beat++;
      end
      @(negedge clk);
      ready = 1'b0;
      drive(1'b1, beat, (beat % 8) == 0);
      #1;
      check("p2_beat24_id", s_wdata, 24);
      check("p2_beat24_swready", b_swready, 1);
      @(negedge clk);
      drive(1'b0, 0, 1'b0);
      ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         check("p2_rest_data", b_data, 8 + k);
         check("p2_rest_last", b_last, (k % 8) == 0);
      end
      @(negedge clk);
      #1;
      check("p2_end_valid", b_valid, 0);
      check("p2_end_inprog", b_inprog, 0);

      // ---- Dropping mode: third burst dropped, AXI never stalled by the tap
      do_reset();
      for (int n = 1; n <= 24; n++) begin
         if (n == 20) begin
            @(negedge clk);
            m_wready = 1'b0;
            drive(1'b1, n, 1'b0);
            #1;
            check("p3_follow_swready", d_swready, 0);
            check("p3_follow_mwvalid", d_mwvalid, 1);
         end
         @(negedge clk);
         m_wready = 1'b1;
         drive(1'b1, n, (n % 8) == 0);
         #1;
         check("p3_swready", d_swready, 1);
         check("p3_mwvalid", d_mwvalid, 1);
      end
      @(negedge clk);
      drive(1'b0, 0, 1'b0);
      #1;
      check("p3_drop", d_drop, 1);
      check("p3_valid", d_valid, 1);
      ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         check("p3_drain_data", d_data, k);
         check("p3_drain_last", d_last, (k % 8) == 0);
      end
      @(negedge clk);
      #1;
      check("p3_end_valid", d_valid, 0);
      check("p3_end_drop", d_drop, 1);

      // ---- Oversize: 10-beat burst, 8 stored with forced last
      do_reset();
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         drive(1'b1, 100 + n, n == 10);
         #1;
         check("p4_mwdata", b_mwdata, 100 + n);
         check("p4_mwvalid", b_mwvalid, 1);
         check("p4_mwlast", b_mwlast, (n == 10));
         if (n == 9) check("p4_over_pre", b_over, 0);
      end
      @(negedge clk);
      drive(1'b0, 0, 1'b0);
      #1;
      check("p4_over", b_over, 1);
      check("p4_valid", b_valid, 1);
      ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         check("p4_data", b_data, 100 + k);
         check("p4_last", b_last, (k == 8));
      end
      @(negedge clk);
      #1;
      check("p4_end_valid", b_valid, 0);
      check("p4_over_sticky", b_over, 1);

      // ---- Back-to-back 2-beat bursts with ready held high
      do_reset();
      ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i < 6) drive(1'b1, 201 + i, (i % 2) == 1);
         else       drive(1'b0, 0, 1'b0);
         #1;
         check("p5_valid", b_valid, (i >= 2 && i <= 7));
         check("p5_inprog", b_inprog, (i >= 2 && i <= 7));
         if (i >= 2 && i <= 7) begin
            check("p5_data", b_data, 199 + i);
            check("p5_last", b_last, (i % 2) == 1);
         end
      end

      // ---- Reset during beat 3 of a stream, then a fresh 2-beat burst
      do_reset();
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         drive(1'b1, 300 + n, n == 4);
      end
      @(negedge clk);
      drive(1'b0, 0, 1'b0);
      ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         if (k > 1) @(negedge clk);
         #1;
         check("p6_data", b_data, 300 + k);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("p6_rst_valid", b_valid, 0);
      check("p6_rst_inprog", b_inprog, 0);
      check("p6_rst_drop", b_drop, 0);
      check("p6_rst_drop_d", d_drop, 0);
      check("p6_rst_data", b_data, 0);
      check("p6_rst_last", b_last, 0);
      @(negedge clk);
      drive(1'b1, 311, 1'b0);
      @(negedge clk);
      drive(1'b1, 312, 1'b1);
      @(negedge clk);
      drive(1'b0, 0, 1'b0);
      #1;
      check("p6_new_valid", b_valid, 1);
      check("p6_new_data0", b_data, 311);
      check("p6_new_last0", b_last, 0);
      @(negedge clk);
      #1;
      check("p6_new_data1", b_data, 312);
      check("p6_new_last1", b_last, 1);
      @(negedge clk);
      #1;
      check("p6_end_valid", b_valid, 0);
      check("p6_end_inprog", b_inprog, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
